// File: rtl/avl_burst_slave_bridge.sv
// avl_burst_slave_bridge
//   Terminates a burst-capable memory-mapped master (e.g. a cache's line refill and
//   write-back port) and replays each burst as single-word accesses on a pipelined,
//   non-burst downstream port.
//
// Ports
//   clk, rest                 clock, asynchronous active-low reset
//   s0_*  (slave, burst)      address/byteEnable/read/write/writeData/burstCount in,
//                             waitRequest/readData/readDataValid out
//   m0_*  (master, single)    address/byteEnable/read/write/writeData out,
//                             waitRequest/readData/readDataValid in
module avl_burst_slave_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BURST_W = 8
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic [DATA_W/8-1:0]   s0_byteEnable,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writeData,
  input  logic                  s0_beginBurstTransfer,
  input  logic [BURST_W-1:0]    s0_burstCount,
  output logic                  s0_waitRequest,
  output logic [DATA_W-1:0]     s0_readData,
  output logic                  s0_readDataValid,
  output logic [ADDR_W-1:0]     m0_address,
  output logic [DATA_W/8-1:0]   m0_byteEnable,
  output logic                  m0_read,
  output logic                  m0_write,
  output logic [DATA_W-1:0]     m0_writeData,
  input  logic                  m0_waitRequest,
  input  logic [DATA_W-1:0]     m0_readData,
  input  logic                  m0_readDataValid
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = BURST_W + 1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdIssue = 2'd1,
    StRdDrain = 2'd2,
    StWr      = 2'd3
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_outstanding;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic [CNT_W-1:0]  w_len_in;
  logic [CNT_W-1:0]  w_len_m1;
  logic [ADDR_W-1:0] w_base_in;
  logic [ADDR_W-1:0] w_rd_off;
  logic [ADDR_W-1:0] w_wr_off;
  logic              w_rd_accept;
  logic              w_rd_last;
  logic              w_wr_accept;
  logic              w_wr_last;
  logic              w_rd_ret;
  logic [CNT_W-1:0]  w_out_nxt;
  logic              w_unused;

  // Address LSBs are forced to word alignment; beginBurstTransfer carries no control.
  assign w_unused = ^{s0_beginBurstTransfer, s0_address[1:0]};

  // A burst count of zero is handled as a single beat.
  assign w_len_in  = (s0_burstCount == '0) ? CntOne : {1'b0, s0_burstCount};
  assign w_len_m1  = r_len - CntOne;
  assign w_base_in = {s0_address[ADDR_W-1:2], 2'b00};

  // Beat offsets in bytes; the add into r_base wraps naturally at 2^ADDR_W.
  assign w_rd_off = ADDR_W'({r_issued, 2'b00});
  assign w_wr_off = ADDR_W'({r_idx, 2'b00});

  assign w_rd_accept = (r_state == StRdIssue) && !m0_waitRequest;
  assign w_rd_last   = w_rd_accept && (r_issued == w_len_m1);
  assign w_wr_accept = (r_state == StWr) && s0_write && !m0_waitRequest;
  assign w_wr_last   = w_wr_accept && (r_idx == w_len_m1);

  // Returns with nothing outstanding are still forwarded but never decrement past 0.
  assign w_rd_ret = m0_readDataValid && (r_outstanding != '0);

  always_comb begin
    w_out_nxt = r_outstanding;
    if ((r_state == StIdle) && s0_read && !s0_write) begin
      w_out_nxt = '0;
    end else if (w_rd_accept && !w_rd_ret) begin
      w_out_nxt = r_outstanding + CntOne;
    end else if (!w_rd_accept && w_rd_ret) begin
      w_out_nxt = r_outstanding - CntOne;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (s0_write) begin
          w_state_nxt = StWr;
        end else if (s0_read) begin
          w_state_nxt = StRdIssue;
        end
      end
      StRdIssue: begin
        if (w_rd_last) w_state_nxt = StRdDrain;
      end
      StRdDrain: begin
        // The final response and the return to idle can share a cycle.
        if (w_out_nxt == '0) w_state_nxt = StIdle;
      end
      StWr: begin
        if (w_wr_last) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    s0_waitRequest = 1'b0;
    m0_address     = '0;
    m0_byteEnable  = '0;
    m0_read        = 1'b0;
    m0_write       = 1'b0;
    m0_writeData   = '0;
    unique case (r_state)
      StIdle: begin
        // A write is only latched here; its first beat is taken in StWr.
        s0_waitRequest = s0_write;
      end
      StRdIssue: begin
        s0_waitRequest = 1'b1;
        m0_read        = 1'b1;
        m0_address     = r_base + w_rd_off;
        m0_byteEnable  = r_be;
      end
      StRdDrain: begin
        s0_waitRequest = 1'b1;
      end
      StWr: begin
        s0_waitRequest = m0_waitRequest;
        m0_write       = s0_write;
        m0_writeData   = s0_writeData;
        m0_byteEnable  = s0_byteEnable;
        m0_address     = r_base + w_wr_off;
      end
      default: s0_waitRequest = 1'b0;
    endcase
  end

  // Burst bookkeeping and the registered read return path.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_base        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_issued      <= '0;
      r_outstanding <= '0;
      r_be          <= '0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
    end else begin
      r_rdata       <= m0_readData;
      r_rvalid      <= m0_readDataValid;
      r_outstanding <= w_out_nxt;
      unique case (r_state)
        StIdle: begin
          if (s0_write) begin
            r_base <= w_base_in;
            r_len  <= w_len_in;
            r_idx  <= '0;
          end else if (s0_read) begin
            r_base   <= w_base_in;
            r_len    <= w_len_in;
            r_be     <= s0_byteEnable;
            r_issued <= '0;
          end
        end
        StRdIssue: begin
          if (w_rd_accept) r_issued <= r_issued + CntOne;
        end
        StWr: begin
          if (w_wr_accept) r_idx <= r_idx + CntOne;
        end
        default: ;
      endcase
    end
  end

  assign s0_readData      = r_rdata;
  assign s0_readDataValid = r_rvalid;

endmodule

// File: tb/tb_avl_burst_slave_bridge.sv
// Bench for avl_burst_slave_bridge: a 1-cycle-latency word memory on m0 with optional
// scripted or random stalls; directed burst scenarios with hand-derived expectations.
module tb_avl_burst_slave_bridge;

  logic        clk;
  logic        rest;
  logic [31:0] s0_address;
  logic [3:0]  s0_byteEnable;
  logic        s0_read;
  logic        s0_write;
  logic [31:0] s0_writeData;
  logic        s0_beginBurstTransfer;
  logic [7:0]  s0_burstCount;
  logic        s0_waitRequest;
  logic [31:0] s0_readData;
  logic        s0_readDataValid;
  logic [31:0] m0_address;
  logic [3:0]  m0_byteEnable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writeData;
  logic        m0_waitRequest;
  logic [31:0] m0_readData;
  logic        m0_readDataValid;

  int unsigned n_pass;
  int unsigned n_total;
  bit          rnd_mode;
  logic [31:0] iss_q[$];
  logic [31:0] ret_q[$];
  logic [31:0] mem[0:1023];

  avl_burst_slave_bridge #(.ADDR_W(32), .DATA_W(32), .BURST_W(8)) dut (
    .clk                   (clk),
    .rest                  (rest),
    .s0_address            (s0_address),
    .s0_byteEnable         (s0_byteEnable),
    .s0_read               (s0_read),
    .s0_write              (s0_write),
    .s0_writeData          (s0_writeData),
    .s0_beginBurstTransfer (s0_beginBurstTransfer),
    .s0_burstCount         (s0_burstCount),
    .s0_waitRequest        (s0_waitRequest),
    .s0_readData           (s0_readData),
    .s0_readDataValid      (s0_readDataValid),
    .m0_address            (m0_address),
    .m0_byteEnable         (m0_byteEnable),
    .m0_read               (m0_read),
    .m0_write              (m0_write),
    .m0_writeData          (m0_writeData),
    .m0_waitRequest        (m0_waitRequest),
    .m0_readData           (m0_readData),
    .m0_readDataValid      (m0_readDataValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream memory: word i resets to 0x5A000000+i, read data returns 1 cycle after accept.
  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      m0_readDataValid <= 1'b0;
      m0_readData      <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 + i;
    end else begin
      m0_readDataValid <= m0_read && !m0_waitRequest;
      m0_readData      <= mem[m0_address[11:2]];
      if (m0_write && !m0_waitRequest) begin
        for (int b = 0; b < 4; b++) begin
          if (m0_byteEnable[b]) mem[m0_address[11:2]][8*b +: 8] <= m0_writeData[8*b +: 8];
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  // Issues one read burst and records accepted m0 addresses and returned s0 data.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] cnt, input int exp_n,
                         input int tail, output bit acc, output int first_iss,
                         output int last_iss, output int first_ret, output int last_ret,
                         output int idle_cyc, output bit tmo);
    iss_q.delete();
    ret_q.delete();
    first_iss = -1; last_iss = -1; first_ret = -1; last_ret = -1; idle_cyc = -1;
    @(negedge clk);
    s0_read = 1'b1; s0_write = 1'b0; s0_address = addr; s0_burstCount = cnt;
    s0_byteEnable = 4'hF;
    if (rnd_mode) m0_waitRequest = ($urandom_range(0, 3) == 0);
    #1;
    acc = (s0_waitRequest === 1'b0);
    @(negedge clk);
    s0_read = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (rnd_mode) m0_waitRequest = ($urandom_range(0, 3) == 0);
      #1;
      if (m0_read === 1'b1 && m0_waitRequest === 1'b0) begin
        iss_q.push_back(m0_address);
        if (first_iss < 0) first_iss = c;
        last_iss = c;
      end
      if (s0_readDataValid === 1'b1) begin
        ret_q.push_back(s0_readData);
        if (first_ret < 0) first_ret = c;
        last_ret = c;
      end
      if (idle_cyc < 0 && ret_q.size() >= exp_n && s0_waitRequest === 1'b0) idle_cyc = c;
      if (idle_cyc >= 0 && c >= idle_cyc + tail) break;
      @(negedge clk);
    end
    tmo = (idle_cyc < 0);
  endtask

  // Streams one write burst; records stalls, waitRequest mirroring and beat address/data.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] cnt, input int nbeats,
                          input logic [31:0] d0, input bit scripted, output bit idle_ok,
                          output int n_stall, output int mirror_err, output int addr_err,
                          output bit tmo);
    int  b;
    int  st;
    int  c;
    bit  first;
    b = 0; st = 0; c = 0; first = 1'b1;
    idle_ok = 1'b0; n_stall = 0; mirror_err = 0; addr_err = 0;
    while (b < nbeats && c < 300) begin
      @(negedge clk);
      s0_read = 1'b0; s0_write = 1'b1; s0_address = addr; s0_burstCount = cnt;
      s0_byteEnable = 4'hF; s0_writeData = d0 + b;
      if (scripted) m0_waitRequest = ((b == 1 || b == 2) && st < 2);
      else if (rnd_mode) m0_waitRequest = ($urandom_range(0, 3) == 0);
      #1;
      if (first) begin
        idle_ok = (s0_waitRequest === 1'b1 && m0_write === 1'b0);
        first = 1'b0;
      end else begin
        if (s0_waitRequest !== m0_waitRequest || m0_write !== 1'b1) mirror_err++;
        if (s0_waitRequest === 1'b1) begin
          n_stall++;
          st++;
        end else begin
          if (m0_address !== addr + 4 * b || m0_writeData !== d0 + b) addr_err++;
          b++;
          st = 0;
        end
      end
      c++;
    end
    tmo = (b < nbeats);
    @(negedge clk);
    s0_write = 1'b0;
    m0_waitRequest = 1'b0;
  endtask

  task automatic test_reset();
    rest = 1'b0;
    s0_address = '0; s0_byteEnable = '0; s0_read = 1'b0; s0_write = 1'b0;
    s0_writeData = '0; s0_beginBurstTransfer = 1'b0; s0_burstCount = '0;
    m0_waitRequest = 1'b0; rnd_mode = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (s0_waitRequest !== 1'b0) $display("FAIL rst_wait: got %b want 0", s0_waitRequest); else n_pass++;
    n_total++; if (m0_read !== 1'b0) $display("FAIL rst_m0_read: got %b want 0", m0_read); else n_pass++;
    n_total++; if (m0_write !== 1'b0) $display("FAIL rst_m0_write: got %b want 0", m0_write); else n_pass++;
    n_total++; if (s0_readDataValid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", s0_readDataValid); else n_pass++;
    n_total++; if (s0_readData !== 32'h0) $display("FAIL rst_rdata: got %h want 0", s0_readData); else n_pass++;
    @(negedge clk);
    rest = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (s0_waitRequest !== 1'b0 || m0_read !== 1'b0 || m0_write !== 1'b0)
      $display("FAIL post_rst_idle: got wait=%b rd=%b wr=%b want 0 0 0", s0_waitRequest, m0_read, m0_write);
    else n_pass++;
  endtask

  task automatic test_read_burst();
    bit acc, tmo;
    int fi, li, fr, lr, ic;
    do_read(32'h100, 8'd8, 8, 3, acc, fi, li, fr, lr, ic, tmo);
    n_total++; if (acc !== 1'b1) $display("FAIL rd8_accept: got %b want 1", acc); else n_pass++;
    n_total++; if (tmo !== 1'b0) $display("FAIL rd8_timeout: got %b want 0", tmo); else n_pass++;
    n_total++; if (iss_q.size() != 8) $display("FAIL rd8_issues: got %0d want 8", iss_q.size()); else n_pass++;
    n_total++; if (ret_q.size() != 8) $display("FAIL rd8_returns: got %0d want 8", ret_q.size()); else n_pass++;
    for (int i = 0; i < iss_q.size() && i < 8; i++) begin
      n_total++; if (iss_q[i] !== 32'h100 + 4 * i) $display("FAIL rd8_addr[%0d]: got %h want %h", i, iss_q[i], 32'h100 + 4 * i); else n_pass++;
    end
    for (int i = 0; i < ret_q.size() && i < 8; i++) begin
      n_total++; if (ret_q[i] !== 32'h5A00_0040 + i) $display("FAIL rd8_data[%0d]: got %h want %h", i, ret_q[i], 32'h5A00_0040 + i); else n_pass++;
    end
    n_total++; if (li - fi != 7) $display("FAIL rd8_consecutive: got span %0d want 7", li - fi); else n_pass++;
    n_total++; if (fr - fi != 2) $display("FAIL rd8_latency: got %0d want 2", fr - fi); else n_pass++;
    n_total++; if (ic - lr < 0 || ic - lr > 1) $display("FAIL rd8_idle: got idle-lastret %0d want 0..1", ic - lr); else n_pass++;
  endtask

  task automatic test_write_stall();
    bit ok, tmo;
    int ns, me, ae;
    do_write(32'h200, 8'd4, 4, 32'hA0, 1'b1, ok, ns, me, ae, tmo);
    n_total++; if (ok !== 1'b1) $display("FAIL wr4_first_stall: got %b want 1", ok); else n_pass++;
    n_total++; if (tmo !== 1'b0) $display("FAIL wr4_timeout: got %b want 0", tmo); else n_pass++;
    n_total++; if (ns != 4) $display("FAIL wr4_stalls: got %0d want 4", ns); else n_pass++;
    n_total++; if (me != 0) $display("FAIL wr4_mirror: got %0d errors want 0", me); else n_pass++;
    n_total++; if (ae != 0) $display("FAIL wr4_addr_data: got %0d errors want 0", ae); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (mem[32'h80 + i] !== 32'hA0 + i) $display("FAIL wr4_mem[%0d]: got %h want %h", i, mem[32'h80 + i], 32'hA0 + i); else n_pass++;
    end
    // A fresh single-beat write must see the IDLE latch cycle again.
    do_write(32'h210, 8'd1, 1, 32'hA4, 1'b0, ok, ns, me, ae, tmo);
    n_total++; if (ok !== 1'b1) $display("FAIL wr4_back_idle: got %b want 1", ok); else n_pass++;
    n_total++; if (mem[32'h84] !== 32'hA4) $display("FAIL wr1_mem: got %h want a4", mem[32'h84]); else n_pass++;
    n_total++; if (mem[32'h85] !== 32'h5A00_0085) $display("FAIL wr1_no_extra: got %h want 5a000085", mem[32'h85]); else n_pass++;
  endtask

  task automatic test_count_zero();
    bit acc, tmo;
    int fi, li, fr, lr, ic;
    do_read(32'h40, 8'd0, 1, 3, acc, fi, li, fr, lr, ic, tmo);
    n_total++; if (iss_q.size() != 1) $display("FAIL cnt0_issues: got %0d want 1", iss_q.size()); else n_pass++;
    n_total++; if (ret_q.size() != 1) $display("FAIL cnt0_returns: got %0d want 1", ret_q.size()); else n_pass++;
    if (iss_q.size() > 0) begin
      n_total++; if (iss_q[0] !== 32'h40) $display("FAIL cnt0_addr: got %h want 40", iss_q[0]); else n_pass++;
    end
    if (ret_q.size() > 0) begin
      n_total++; if (ret_q[0] !== 32'h5A00_0010) $display("FAIL cnt0_data: got %h want 5a000010", ret_q[0]); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    bit acc, tmo;
    int fi, li, fr, lr, ic;
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    exp_d[0] = 32'h5A00_03FE; exp_d[1] = 32'h5A00_03FF; exp_d[2] = 32'h5A00_0000;
    exp_d[3] = 32'h5A00_0001;
    do_read(32'hFFFF_FFF8, 8'd4, 4, 3, acc, fi, li, fr, lr, ic, tmo);
    n_total++; if (iss_q.size() != 4) $display("FAIL wrap_issues: got %0d want 4", iss_q.size()); else n_pass++;
    for (int i = 0; i < iss_q.size() && i < 4; i++) begin
      n_total++; if (iss_q[i] !== exp_a[i]) $display("FAIL wrap_addr[%0d]: got %h want %h", i, iss_q[i], exp_a[i]); else n_pass++;
    end
    for (int i = 0; i < ret_q.size() && i < 4; i++) begin
      n_total++; if (ret_q[i] !== exp_d[i]) $display("FAIL wrap_data[%0d]: got %h want %h", i, ret_q[i], exp_d[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int  n;
    int  stray;
    bit  ok, tmo;
    int  ns, me, ae;
    n = 0;
    @(negedge clk);
    s0_read = 1'b1; s0_write = 1'b0; s0_address = 32'h400; s0_burstCount = 8'd8;
    s0_byteEnable = 4'hF;
    @(negedge clk);
    s0_read = 1'b0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      #1;
      if (m0_read === 1'b1 && m0_waitRequest === 1'b0) n++;
      @(negedge clk);
    end
    #1;
    n_total++; if (m0_read !== 1'b1) $display("FAIL rstmid_third_issue: got %b want 1", m0_read); else n_pass++;
    rest = 1'b0;
    #1;
    n_total++; if (m0_read !== 1'b0 || m0_write !== 1'b0)
      $display("FAIL rstmid_m0: got rd=%b wr=%b want 0 0", m0_read, m0_write);
    else n_pass++;
    n_total++; if (s0_waitRequest !== 1'b0) $display("FAIL rstmid_wait: got %b want 0", s0_waitRequest); else n_pass++;
    n_total++; if (s0_readDataValid !== 1'b0 || s0_readData !== 32'h0)
      $display("FAIL rstmid_ret: got v=%b d=%h want 0 0", s0_readDataValid, s0_readData);
    else n_pass++;
    @(negedge clk);
    rest = 1'b1;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (s0_readDataValid !== 1'b0) stray++;
      @(negedge clk);
    end
    n_total++; if (stray != 0) $display("FAIL rstmid_stray: got %0d want 0", stray); else n_pass++;
    do_write(32'h300, 8'd2, 2, 32'hB0, 1'b0, ok, ns, me, ae, tmo);
    n_total++; if (ok !== 1'b1 || tmo !== 1'b0) $display("FAIL rstmid_wr: got ok=%b tmo=%b want 1 0", ok, tmo); else n_pass++;
    n_total++; if (mem[32'hC0] !== 32'hB0) $display("FAIL rstmid_mem0: got %h want b0", mem[32'hC0]); else n_pass++;
    n_total++; if (mem[32'hC1] !== 32'hB1) $display("FAIL rstmid_mem1: got %h want b1", mem[32'hC1]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit acc, tmo, ok;
    int fi, li, fr, lr, ic, ns, me, ae, bad;
    rnd_mode = 1'b1;
    do_read(32'h500, 8'd8, 8, 0, acc, fi, li, fr, lr, ic, tmo);
    do_write(32'h600, 8'd8, 8, 32'hD0, 1'b0, ok, ns, me, ae, tmo);
    rnd_mode = 1'b0;
    m0_waitRequest = 1'b0;
    n_total++; if (iss_q.size() != 8) $display("FAIL b2b_rd_issues: got %0d want 8", iss_q.size()); else n_pass++;
    n_total++; if (ret_q.size() != 8) $display("FAIL b2b_rd_returns: got %0d want 8", ret_q.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < iss_q.size() && i < 8; i++) if (iss_q[i] !== 32'h500 + 4 * i) bad++;
    for (int i = 0; i < ret_q.size() && i < 8; i++) if (ret_q[i] !== 32'h5A00_0140 + i) bad++;
    n_total++; if (bad != 0) $display("FAIL b2b_rd_content: got %0d errors want 0", bad); else n_pass++;
    n_total++; if (ok !== 1'b1 || tmo !== 1'b0) $display("FAIL b2b_wr_flow: got ok=%b tmo=%b want 1 0", ok, tmo); else n_pass++;
    n_total++; if (me != 0 || ae != 0) $display("FAIL b2b_wr_beats: got mirror=%0d addr=%0d want 0 0", me, ae); else n_pass++;
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[32'h180 + i] !== 32'hD0 + i) bad++;
    n_total++; if (bad != 0) $display("FAIL b2b_wr_mem: got %0d errors want 0", bad); else n_pass++;
    n_total++; if (mem[32'h188] !== 32'h5A00_0188 || mem[32'h17F] !== 32'h5A00_017F)
      $display("FAIL b2b_wr_bounds: got %h %h want 5a000188 5a00017f", mem[32'h188], mem[32'h17F]);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_read_burst();
    test_write_stall();
    test_count_zero();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
